// File: rtl/ysyx_22050019_ifu_pkg.sv
// Shared IFU definitions: fetch FSM state encoding, reset PC and PC alignment helper.
package ysyx_22050019_ifu_pkg;

   localparam logic [63:0] YSYX_22050019_RESET_PC = 64'h8000_0000;

   typedef enum logic [1:0] {
      StReq   = 2'd0,
      StWait  = 2'd1,
      StHold  = 2'd2,
      StDrain = 2'd3
   } ysyx_22050019_ifu_state_e;

   // Instruction fetch is word aligned, so every PC load clears the low two bits.
   function automatic logic [63:0] ysyx_22050019_align_pc(input logic [63:0] pc);
      return pc & ~64'h3;
   endfunction

endpackage

// File: rtl/ysyx_22050019_ifu_if.sv
// IFU-facing bundle: instruction memory request/response, decode handoff and redirect/flush.
interface ysyx_22050019_ifu_if;

   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        if_resp_ready;
   logic        inst_valid;
   logic        inst_ready;
   logic [63:0] inst_addr_pc;
   logic [31:0] inst_o;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        flush_valid;
   logic [63:0] flush_pc;

   modport master (
      output if_req_valid, if_req_addr, if_resp_ready, inst_valid, inst_addr_pc, inst_o,
      input  if_req_ready, if_resp_valid, if_resp_data, inst_ready, redirect_valid,
             redirect_pc, flush_valid, flush_pc
   );

   modport slave (
      input  if_req_valid, if_req_addr, if_resp_ready, inst_valid, inst_addr_pc, inst_o,
      output if_req_ready, if_resp_valid, if_resp_data, inst_ready, redirect_valid,
             redirect_pc, flush_valid, flush_pc
   );

endinterface

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one outstanding fetch, holds the fetched word until decode takes it,
// and handles decode redirects and pipeline flushes.
module ysyx_22050019_ifu
   import ysyx_22050019_ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = YSYX_22050019_RESET_PC
) (
   input logic                        clk,
   input logic                        rst,
   ysyx_22050019_ifu_if.master        bus
);

   ysyx_22050019_ifu_state_e state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;
   logic        req_valid, resp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StReq;
         pc_q         <= ysyx_22050019_align_pc(RESET_PC);
         inst_valid_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      req_valid    = 1'b0;
      resp_ready   = 1'b0;

      unique case (state_q)
         StReq: begin
            req_valid = 1'b1;
            if (bus.flush_valid) begin
               pc_d = ysyx_22050019_align_pc(bus.flush_pc);
               // An accepted request still owes us a response; swallow it in DRAIN.
               state_d = bus.if_req_ready ? StDrain : StReq;
            end else if (bus.if_req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            resp_ready = 1'b1;
            if (bus.flush_valid) begin
               pc_d    = ysyx_22050019_align_pc(bus.flush_pc);
               state_d = bus.if_resp_valid ? StReq : StDrain;
            end else if (bus.if_resp_valid) begin
               inst_d       = bus.if_resp_data;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               state_d      = StHold;
            end
         end
         StHold: begin
            if (bus.flush_valid) begin
               pc_d         = ysyx_22050019_align_pc(bus.flush_pc);
               inst_valid_d = 1'b0;
               state_d      = StReq;
            end else if (bus.inst_ready) begin
               pc_d = bus.redirect_valid ? ysyx_22050019_align_pc(bus.redirect_pc)
                                         : ysyx_22050019_align_pc(pc_q + 64'd4);
               inst_valid_d = 1'b0;
               state_d      = StReq;
            end
         end
         StDrain: begin
            resp_ready = 1'b1;
            if (bus.flush_valid) begin
               pc_d = ysyx_22050019_align_pc(bus.flush_pc);
            end
            if (bus.if_resp_valid) begin
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase
   end

   assign bus.if_req_valid  = req_valid;
   assign bus.if_req_addr   = pc_q;
   assign bus.if_resp_ready = resp_ready;
   assign bus.inst_valid    = inst_valid_q;
   assign bus.inst_o        = inst_q;
   assign bus.inst_addr_pc  = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Directed cycle-by-cycle vectors for the IFU plus a reset-during-fetch sequence.
module tb_ysyx_22050019_ifu;

   typedef struct {
      logic        req_ready;
      logic        resp_valid;
      logic [31:0] resp_data;
      logic        inst_ready;
      logic        redir_v;
      logic [63:0] redir_pc;
      logic        flush_v;
      logic [63:0] flush_pc;
      logic        e_req_valid;
      logic [63:0] e_addr;
      logic        e_resp_ready;
      logic        e_inst_valid;
      logic [63:0] e_inst_pc;
      logic [31:0] e_inst;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   ysyx_22050019_ifu_if bus();

   ysyx_22050019_ifu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rv, input logic [63:0] a,
                             input logic rr, input logic iv, input logic [63:0] ipc,
                             input logic [31:0] inst);
      check({tag, ".req_valid"}, 64'(bus.if_req_valid), 64'(rv));
      check({tag, ".req_addr"}, bus.if_req_addr, a);
      check({tag, ".resp_ready"}, 64'(bus.if_resp_ready), 64'(rr));
      check({tag, ".inst_valid"}, 64'(bus.inst_valid), 64'(iv));
      check({tag, ".inst_pc"}, bus.inst_addr_pc, ipc);
      check({tag, ".inst"}, 64'(bus.inst_o), 64'(inst));
   endtask

   task automatic add(input logic rq, input logic rsv, input logic [31:0] d, input logic ir,
                      input logic rdv, input logic [63:0] rdp, input logic fv,
                      input logic [63:0] fp, input logic erv, input logic [63:0] ea,
                      input logic err, input logic eiv, input logic [63:0] eipc,
                      input logic [31:0] einst);
      vec_t v;
      v = '{rq, rsv, d, ir, rdv, rdp, fv, fp, erv, ea, err, eiv, eipc, einst};
      vecs.push_back(v);
   endtask

   task automatic drive_idle();
      bus.if_req_ready   = 1'b0;
      bus.if_resp_valid  = 1'b0;
      bus.if_resp_data   = 32'h0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'h0;
      bus.flush_valid    = 1'b0;
      bus.flush_pc       = 64'h0;
   endtask

   initial begin
      // req_ready resp_valid data inst_ready redir redir_pc flush flush_pc |
      // exp: req_valid addr resp_ready inst_valid inst_pc inst
      add(1,0,0,          0,0,0,           0,0,           1,64'h80000000,0,0,0,0);
      add(0,1,32'h413,    0,0,0,           0,0,           0,64'h80000000,1,0,0,0);
      add(0,0,0,          1,0,0,           0,0,           0,64'h80000000,0,1,64'h80000000,32'h413);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80000004,0,0,64'h80000000,32'h413);
      add(0,1,32'h100093, 0,0,0,           0,0,           0,64'h80000004,1,0,64'h80000000,32'h413);
      add(0,0,0,          1,1,64'h80000103,0,0,           0,64'h80000004,0,1,64'h80000004,32'h100093);
      add(0,0,0,          0,0,0,           0,0,           1,64'h80000100,0,0,64'h80000004,32'h100093);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80000100,0,0,64'h80000004,32'h100093);
      add(0,0,0,          0,0,0,           0,0,           0,64'h80000100,1,0,64'h80000004,32'h100093);
      add(0,1,32'h13,     0,0,0,           0,0,           0,64'h80000100,1,0,64'h80000004,32'h100093);
      for (int i = 0; i < 5; i++) begin
         add(0,0,0,       0,1,64'h12345678,0,0,           0,64'h80000100,0,1,64'h80000100,32'h13);
      end
      add(0,0,0,          1,0,0,           0,0,           0,64'h80000100,0,1,64'h80000100,32'h13);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80000104,0,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           1,64'h80001000,0,64'h80000104,1,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           0,0,           0,64'h80001000,1,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           0,0,           0,64'h80001000,1,0,64'h80000100,32'h13);
      add(0,1,32'hdeadbeef,0,0,0,          0,0,           0,64'h80001000,1,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           0,0,           1,64'h80001000,0,0,64'h80000100,32'h13);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80001000,0,0,64'h80000100,32'h13);
      add(0,1,32'hcafe,   0,0,0,           1,64'h80002002,0,64'h80001000,1,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           0,0,           1,64'h80002000,0,0,64'h80000100,32'h13);
      add(1,0,0,          0,0,0,           1,64'h80003000,1,64'h80002000,0,0,64'h80000100,32'h13);
      add(0,0,0,          0,0,0,           0,0,           0,64'h80003000,1,0,64'h80000100,32'h13);
      add(0,1,32'h11111111,0,0,0,          0,0,           0,64'h80003000,1,0,64'h80000100,32'h13);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80003000,0,0,64'h80000100,32'h13);
      add(0,1,32'h73,     0,0,0,           0,0,           0,64'h80003000,1,0,64'h80000100,32'h13);
      add(0,0,0,          1,1,64'h1,       1,64'hffffffffffffffff,
          0,64'h80003000,0,1,64'h80003000,32'h73);
      add(1,0,0,          0,0,0,           0,0,           1,64'hfffffffffffffffc,0,0,64'h80003000,32'h73);
      add(0,1,32'h1,      0,0,0,           0,0,           0,64'hfffffffffffffffc,1,0,64'h80003000,32'h73);
      add(0,0,0,          1,0,0,           0,0,
          0,64'hfffffffffffffffc,0,1,64'hfffffffffffffffc,32'h1);
      add(0,0,0,          0,0,0,           0,0,           1,64'h0,0,0,64'hfffffffffffffffc,32'h1);
      add(0,0,0,          0,0,0,           1,64'h80000000,1,64'h0,0,0,64'hfffffffffffffffc,32'h1);
      add(1,0,0,          0,0,0,           0,0,           1,64'h80000000,0,0,64'hfffffffffffffffc,32'h1);
      add(0,1,32'h2,      0,0,0,           0,0,           0,64'h80000000,1,0,64'hfffffffffffffffc,32'h1);
      add(0,0,0,          0,0,0,           1,64'h80004000,0,64'h80000000,0,1,64'h80000000,32'h2);
      add(0,0,0,          0,0,0,           0,0,           1,64'h80004000,0,0,64'h80000000,32'h2);

      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 1'b1, 64'h80000000, 1'b0, 1'b0, 64'h0, 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         bus.if_req_ready   = vecs[i].req_ready;
         bus.if_resp_valid  = vecs[i].resp_valid;
         bus.if_resp_data   = vecs[i].resp_data;
         bus.inst_ready     = vecs[i].inst_ready;
         bus.redirect_valid = vecs[i].redir_v;
         bus.redirect_pc    = vecs[i].redir_pc;
         bus.flush_valid    = vecs[i].flush_v;
         bus.flush_pc       = vecs[i].flush_pc;
         #1;
         check_outs($sformatf("v%0d", i), vecs[i].e_req_valid, vecs[i].e_addr,
                    vecs[i].e_resp_ready, vecs[i].e_inst_valid, vecs[i].e_inst_pc,
                    vecs[i].e_inst);
         @(posedge clk);
         #1;
      end

      // Reset asserted while a fetch is outstanding: outputs return to reset values at once.
      drive_idle();
      bus.if_req_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.if_req_ready = 1'b0;
      check("rst_mid.in_wait", 64'(bus.if_resp_ready), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      check_outs("rst_mid", 1'b1, 64'h80000000, 1'b0, 1'b0, 64'h0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_outs("rst_rel", 1'b1, 64'h80000000, 1'b0, 1'b0, 64'h0, 32'h0);
      // Fresh fetch after reset with no drain of the abandoned one.
      bus.if_req_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.if_req_ready  = 1'b0;
      bus.if_resp_valid = 1'b1;
      bus.if_resp_data  = 32'h5;
      @(posedge clk);
      #1;
      bus.if_resp_valid = 1'b0;
      check_outs("rst_fetch", 1'b0, 64'h80000000, 1'b0, 1'b1, 64'h80000000, 32'h5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
